// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART with STATUS/DATA/CTRL/BAUD registers and a programmable bit period
module uart_mmio #(
  parameter logic [15:0] DEFAULT_BAUD = 16'd868,
  parameter logic [27:0] UART_BASE_ADDRESS = 28'h1600000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wr_en,
  input  logic        rd_en,
  output logic [31:0] rdata,
  output logic        tx,
  input  logic        rx
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t tx_state, rx_state;
  logic tx_en, rx_en, tx_full, rx_valid, rx_overrun, rx_frame_err;
  logic [15:0] baud, per, half, tx_cnt, rx_cnt;
  logic [7:0] tx_hold, tx_shift, rx_shift, rx_byte;
  logic [2:0] tx_bit, rx_bit;
  logic [1:0] rx_sync;
  logic rx_prev, sel, st_wr, dat_wr, ctl_wr, bd_wr, dat_rd, rx_end, rx_ok, rx_bad, rx_store, unused_bits;
  assign sel = addr[31:4] == UART_BASE_ADDRESS;
  assign st_wr = sel && wr_en && addr[3:0] == 4'h0;
  assign dat_wr = sel && wr_en && addr[3:0] == 4'h4;
  assign ctl_wr = sel && wr_en && addr[3:0] == 4'h8;
  assign bd_wr = sel && wr_en && addr[3:0] == 4'hC;
  assign dat_rd = sel && rd_en && addr[3:0] == 4'h4;
  assign unused_bits = ^wdata[31:16];
  assign per = baud < 16'd2 ? 16'd2 : baud;
  assign half = {1'b0, per[15:1]} - 16'd1;
  assign rx_end = rx_en && rx_state == STOP && rx_cnt == 16'd0;
  assign rx_ok = rx_end && rx_sync[1];
  assign rx_bad = rx_end && !rx_sync[1];
  assign rx_store = rx_ok && (!rx_valid || dat_rd);
  assign rdata = !sel ? 32'd0 :
                 addr[3:0] == 4'h0 ? {27'd0, rx_frame_err, rx_overrun, rx_valid, tx_full, tx_state != IDLE} :
                 addr[3:0] == 4'h4 ? {24'd0, rx_byte} :
                 addr[3:0] == 4'h8 ? {30'd0, rx_en, tx_en} :
                 addr[3:0] == 4'hC ? {16'd0, baud} : 32'd0;
  // A pending byte leaves STOP straight into START so back-to-back frames have no gap
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= IDLE;
      tx <= 1'b1;
      tx_full <= 1'b0;
      tx_hold <= '0;
      tx_shift <= '0;
      tx_cnt <= '0;
      tx_bit <= '0;
    end else begin
      if (dat_wr && tx_en && !tx_full) begin
        tx_hold <= wdata[7:0];
        tx_full <= 1'b1;
      end
      case (tx_state)
        START:
          if (tx_cnt != 16'd0) tx_cnt <= tx_cnt - 16'd1;
          else begin
            tx_state <= DATA;
            tx_cnt <= per - 16'd1;
            tx_bit <= '0;
            tx <= tx_shift[0];
          end
        DATA:
          if (tx_cnt != 16'd0) tx_cnt <= tx_cnt - 16'd1;
          else begin
            tx_cnt <= per - 16'd1;
            tx_bit <= tx_bit + 3'd1;
            tx_shift <= tx_shift >> 1;
            tx <= tx_bit == 3'd7 ? 1'b1 : tx_shift[1];
            tx_state <= tx_bit == 3'd7 ? STOP : DATA;
          end
        default:
          if (tx_state == STOP && tx_cnt != 16'd0) tx_cnt <= tx_cnt - 16'd1;
          else if (tx_full) begin
            tx_shift <= tx_hold;
            tx_full <= 1'b0;
            tx_state <= START;
            tx_cnt <= per - 16'd1;
            tx <= 1'b0;
          end else tx_state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
      rx_state <= IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_shift <= '0;
    end else if (!rx_en) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
      rx_state <= IDLE;
    end else begin
      rx_sync <= {rx_sync[0], rx};
      rx_prev <= rx_sync[1];
      case (rx_state)
        IDLE:
          if (rx_prev && !rx_sync[1]) begin
            rx_state <= START;
            rx_cnt <= half;
          end
        START:
          if (rx_cnt != 16'd0) rx_cnt <= rx_cnt - 16'd1;
          else begin
            rx_state <= rx_sync[1] ? IDLE : DATA;
            rx_cnt <= per - 16'd1;
            rx_bit <= '0;
          end
        DATA:
          if (rx_cnt != 16'd0) rx_cnt <= rx_cnt - 16'd1;
          else begin
            rx_shift <= {rx_sync[1], rx_shift[7:1]};
            rx_cnt <= per - 16'd1;
            rx_bit <= rx_bit + 3'd1;
            rx_state <= rx_bit == 3'd7 ? STOP : DATA;
          end
        default:
          if (rx_cnt != 16'd0) rx_cnt <= rx_cnt - 16'd1;
          else rx_state <= IDLE;
      endcase
    end
  end
  // Hardware set of a flag takes priority over a same-cycle software clear
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_en <= 1'b0;
      rx_en <= 1'b0;
      baud <= DEFAULT_BAUD;
      rx_byte <= '0;
      rx_valid <= 1'b0;
      rx_overrun <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (ctl_wr) {rx_en, tx_en} <= wdata[1:0];
      if (bd_wr) baud <= wdata[15:0];
      if (rx_store) rx_byte <= rx_shift;
      rx_valid <= rx_ok || (rx_valid && !dat_rd);
      rx_overrun <= (rx_ok && rx_valid && !dat_rd) || (rx_overrun && !(st_wr && wdata[3]));
      rx_frame_err <= rx_bad || (rx_frame_err && !(st_wr && wdata[4]));
    end
  end
endmodule

// File: doc/uart_mmio.md
UART_MMIO -- requirements
Module: uart_mmio

Interface
REQ-001 SHALL have parameter DEFAULT_BAUD, default 16'd868, reset value of the BAUD register (clocks per bit).
REQ-002 SHALL have parameter UART_BASE_ADDRESS, default 28'h1600000, matched against addr[31:4].
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port addr  input  32  byte address from the load/store stage.
REQ-006 SHALL have port wdata  input  32  store data.
REQ-007 SHALL have port wr_en  input  1  store strobe, one cycle per access.
REQ-008 SHALL have port rd_en  input  1  load strobe, one cycle per access.
REQ-009 SHALL have port rdata  output  32  load data, combinational, same cycle as rd_en.
REQ-010 SHALL have port tx  output  1  serial transmit line, idle high.
REQ-011 SHALL have port rx  input  1  serial receive line, asynchronous.

Function
REQ-012 SHALL select the block when addr[31:4]==UART_BASE_ADDRESS; offset addr[3:0]: STATUS=0x0, DATA=0x4, CTRL=0x8, BAUD=0xC; other offsets or unselected: rdata=0, no side effects.
REQ-013 SHALL treat every access as a 32-bit word; unused read bits SHALL be 0.
REQ-014 STATUS (read): bit0 tx_busy (FSM not IDLE), bit1 tx_full (holding register valid), bit2 rx_valid, bit3 rx_overrun, bit4 rx_frame_err; write: 1 in bit3/bit4 clears that flag, other bits ignored.
REQ-015 CTRL: bit0 tx_en, bit1 rx_en, read/write, other bits read 0.
REQ-016 BAUD: bits[15:0] divisor D, read/write; effective period = max(D,2) clocks; a new value applies from the next bit-counter reload.
REQ-017 DATA write: if tx_en=1 and tx_full=0, load wdata[7:0] into holding register and set tx_full; otherwise drop silently.
REQ-018 DATA read: rdata[7:0]=rx byte; at the same edge clear rx_valid.
REQ-019 TX FSM states IDLE, START, DATA, STOP; 8N1, LSB first; each state bit lasts exactly the effective period.
REQ-020 IDLE with tx_full=1: move byte into shift register, clear tx_full, enter START on the next edge; tx=0 from that edge, i.e. one cycle after the write edge.
REQ-021 After STOP (tx=1 for one period), return to IDLE; a byte already in the holding register SHALL start on the next edge with no extra idle bit.
REQ-022 RX SHALL pass rx through a 2-flop synchronizer, active only when rx_en=1.
REQ-023 RX FSM states IDLE, START, DATA, STOP; IDLE->START on synchronized falling edge; at period/2 into START, if line high return IDLE (false start), else sample 8 data bits each one period apart, then the stop bit.
REQ-024 Stop=1: if rx_valid=0, store byte and set rx_valid; if rx_valid=1, discard byte and set rx_overrun.
REQ-025 Stop=0: discard byte, set rx_frame_err; return IDLE after line high.
REQ-026 DATA read clearing rx_valid on the same edge a new byte completes: store the new byte, rx_valid stays 1, no overrun.
REQ-027 W1C clear and hardware set of the same flag on one edge: set wins.
REQ-028 Clearing tx_en mid-frame SHALL finish the current frame; clearing rx_en SHALL return RX to IDLE on the next edge.

Reset
REQ-029 On rst: tx=1, TX/RX FSMs IDLE, tx_full=0, rx_valid=0, rx_overrun=0, rx_frame_err=0, CTRL=0, BAUD=DEFAULT_BAUD, holding/shift/rx byte=0, counters=0.
REQ-030 Reset mid-frame SHALL abort immediately; tx high from the next edge, partial RX byte discarded.

Verification
REQ-031 BAUD=4, CTRL=1, write DATA=0xA5 at edge k -> tx low edges k+1..k+4, then bits 1,0,1,0,0,1,0,1 four cycles each, stop high, tx_busy=0 at k+41.
REQ-032 CTRL=1, two back-to-back DATA writes 0x11, 0x22, third write while tx_full=1 -> third dropped; 0x22 start bit immediately follows 0x11 stop bit.
REQ-033 BAUD=8, CTRL=2, drive 0x3C frame on rx -> STATUS=0x04, DATA read=0x3C, next STATUS=0x00.
REQ-034 Two frames 0x01, 0x02 without reading -> DATA=0x01, rx_overrun=1; write STATUS=0x08 -> overrun=0.
REQ-035 Frame with stop bit 0 -> rx_frame_err=1, rx_valid=0; 2-cycle low glitch on rx -> no state change.
REQ-036 Assert rst during TX data bit 3 -> tx=1 next edge, STATUS=0, BAUD=868, CTRL=0.
